// File: rtl/qoa_spi_byte_rx.sv
// SPI mode-0 slave byte receiver: oversamples SCK/CS_N/MOSI in sys_clk and strobes each completed byte.
// Optional MISO echo of the previous byte is built when QOA_SPI_ECHO_EN is defined.
module qoa_spi_byte_rx #(
    parameter int SYNC_STAGES = 2,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       spi_sck,
    input  logic       spi_cs_n,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic [7:0] spi_byte,
    output logic       data_rdy,
    output logic       frame_err
);

    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] cs_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sck_dly_q;
    logic                   cs_dly_q;
    logic                   sck_s;
    logic                   cs_s;
    logic                   mosi_s;
    logic                   sck_rise;
    logic                   cs_fall;
    logic                   cs_rise;

    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [7:0] sr_q, sr_d;
    logic [7:0] byte_q, byte_d;
    logic       rdy_q, rdy_d;
    logic       ferr_q, ferr_d;

    function automatic logic [7:0] shift_in(input logic [7:0] sr, input logic b);
        if (MSB_FIRST) begin
            shift_in = {sr[6:0], b};
        end else begin
            shift_in = {b, sr[7:1]};
        end
    endfunction

    // Input synchronizers plus one extra stage on sck/cs_n for edge detection.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            sck_sync_q  <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sck_dly_q   <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], spi_sck};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
            sck_dly_q   <= sck_s;
            cs_dly_q    <= cs_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign cs_s     = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_dly_q;
    assign cs_fall  = ~cs_s & cs_dly_q;
    assign cs_rise  = cs_s & ~cs_dly_q;

    // Receive datapath: cs edges take priority; an sck_rise with cs_fall is bit 0.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        sr_d      = sr_q;
        byte_d    = byte_q;
        rdy_d     = 1'b0;
        ferr_d    = 1'b0;
        if (cs_rise) begin
            bit_cnt_d = 3'd0;
            sr_d      = 8'h00;
            ferr_d    = (bit_cnt_q != 3'd0);
        end else if (cs_fall) begin
            if (sck_rise) begin
                sr_d      = shift_in(8'h00, mosi_s);
                bit_cnt_d = 3'd1;
            end else begin
                sr_d      = 8'h00;
                bit_cnt_d = 3'd0;
            end
        end else if (!cs_s) begin
            if (sck_rise) begin
                sr_d      = shift_in(sr_q, mosi_s);
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_d = shift_in(sr_q, mosi_s);
                    rdy_d  = 1'b1;
                end else begin
                    rdy_d  = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q;
            end
        end else begin
            bit_cnt_d = 3'd0;
        end
    end

    // Receive state and registered strobes.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            bit_cnt_q <= 3'd0;
            sr_q      <= 8'h00;
            byte_q    <= 8'h00;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            sr_q      <= sr_d;
            byte_q    <= byte_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
        end
    end

    assign spi_byte  = byte_q;
    assign data_rdy  = rdy_q;
    assign frame_err = ferr_q;

`ifdef QOA_SPI_ECHO_EN
    logic       sck_fall;
    logic [7:0] tx_sr_q, tx_sr_d;
    logic       miso_q, miso_d;

    function automatic logic first_bit(input logic [7:0] v);
        if (MSB_FIRST) begin
            first_bit = v[7];
        end else begin
            first_bit = v[0];
        end
    endfunction

    function automatic logic [7:0] shift_out(input logic [7:0] v);
        if (MSB_FIRST) begin
            shift_out = {v[6:0], 1'b0};
        end else begin
            shift_out = {1'b0, v[7:1]};
        end
    endfunction

    assign sck_fall = ~sck_s & sck_dly_q;

    // The falling edge right after completion is skipped (bit_cnt==0) so the reloaded byte keeps its first bit.
    always_comb begin
        tx_sr_d = tx_sr_q;
        if (cs_fall) begin
            tx_sr_d = byte_q;
        end else if (rdy_d) begin
            tx_sr_d = byte_d;
        end else if (!cs_s && sck_fall && (bit_cnt_q != 3'd0)) begin
            tx_sr_d = shift_out(tx_sr_q);
        end else begin
            tx_sr_d = tx_sr_q;
        end
        miso_d = cs_s ? 1'b0 : first_bit(tx_sr_d);
    end

    // Echo shift register and registered MISO.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            tx_sr_q <= 8'h00;
            miso_q  <= 1'b0;
        end else begin
            tx_sr_q <= tx_sr_d;
            miso_q  <= miso_d;
        end
    end

    assign spi_miso = miso_q;
`else
    assign spi_miso = 1'b0;
`endif

endmodule

// File: tb/tb_qoa_spi_byte_rx.sv
// Scoreboard bench for qoa_spi_byte_rx: host SPI stimulus at sys_clk/8, expected bytes queued per frame.
module tb_qoa_spi_byte_rx;

    logic       sys_clk   = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       spi_sck   = 1'b0;
    logic       spi_cs_n  = 1'b1;
    logic       spi_mosi  = 1'b0;
    logic       spi_miso;
    logic [7:0] spi_byte;
    logic       data_rdy;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         rdy_cnt  = 0;
    int         ferr_cnt = 0;
    logic [7:0] exp_q[$];
    logic [7:0] prev_byte = 8'h00;
    logic       prev_rdy  = 1'b0;

    qoa_spi_byte_rx #(.SYNC_STAGES(2), .MSB_FIRST(1'b1)) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .spi_sck  (spi_sck),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .spi_miso (spi_miso),
        .spi_byte (spi_byte),
        .data_rdy (data_rdy),
        .frame_err(frame_err)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops the scoreboard on each strobe and checks pulse properties.
    always @(posedge sys_clk) begin
        #1;
        if (sys_rst_n) begin
            check_eq("rdy_ferr_excl", {31'd0, data_rdy & frame_err}, 32'd0);
            if (data_rdy) begin
                rdy_cnt++;
                check_eq("rdy_width", {31'd0, prev_rdy}, 32'd0);
                if (exp_q.size() == 0) begin
                    check_eq("rdy_unexpected", {24'd0, spi_byte}, 32'hFFFF_FFFF);
                end else begin
                    check_eq("byte", {24'd0, spi_byte}, {24'd0, exp_q.pop_front()});
                end
            end else begin
                check_eq("byte_hold", {24'd0, spi_byte}, {24'd0, prev_byte});
            end
            if (frame_err) ferr_cnt++;
        end
        prev_byte = spi_byte;
        prev_rdy  = data_rdy;
    end

    task automatic half_period();
        repeat (4) @(negedge sys_clk);
    endtask

    task automatic send_bit(input logic b, output logic m);
        spi_mosi = b;
        half_period();
        m = spi_miso;
        spi_sck = 1'b1;
        half_period();
        spi_sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, output logic [7:0] echo);
        logic m;
        exp_q.push_back(d);
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], m);
            echo[i] = m;
        end
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        half_period();
    endtask

    task automatic frame_end();
        half_period();
        spi_cs_n = 1'b1;
        repeat (8) @(negedge sys_clk);
    endtask

    initial begin
        logic [7:0] echo;
        logic       m;
        int         rdy_before;
        int         wait_cycles;

        repeat (3) @(negedge sys_clk);
        @(posedge sys_clk);
        #1;
        check_eq("rst_byte", {24'd0, spi_byte}, 32'd0);
        check_eq("rst_rdy", {31'd0, data_rdy}, 32'd0);
        check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
        check_eq("rst_miso", {31'd0, spi_miso}, 32'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        repeat (4) @(negedge sys_clk);

        // Single byte
        frame_start();
        send_byte(8'hA5, echo);
        frame_end();
        check_eq("a5_byte", {24'd0, spi_byte}, 32'h0000_00A5);
        check_eq("a5_no_ferr", ferr_cnt, 0);

        // Burst of three bytes in one frame
        frame_start();
        send_byte(8'h01, echo);
        send_byte(8'hF0, echo);
        send_byte(8'h3C, echo);
        frame_end();
        check_eq("burst_last", {24'd0, spi_byte}, 32'h0000_003C);
        check_eq("burst_rdy_cnt", rdy_cnt, 4);

        // Aborted frame after 5 bits, then a clean byte
        frame_start();
        for (int i = 0; i < 5; i++) send_bit(1'b1, m);
        frame_end();
        check_eq("abort_ferr", ferr_cnt, 1);
        check_eq("abort_hold", {24'd0, spi_byte}, 32'h0000_003C);
        frame_start();
        send_byte(8'h12, echo);
        frame_end();
        check_eq("after_abort", {24'd0, spi_byte}, 32'h0000_0012);

        // SCK activity while deselected must be ignored
        rdy_before = rdy_cnt;
        for (int i = 0; i < 10; i++) begin
            send_bit(1'b1, m);
            check_eq("idle_miso", {31'd0, m}, 32'd0);
        end
        repeat (8) @(negedge sys_clk);
        check_eq("idle_no_rdy", rdy_cnt, rdy_before);
        frame_start();
        send_byte(8'h00, echo);
        frame_end();
        check_eq("zero_byte", {24'd0, spi_byte}, 32'd0);

        // Reset mid-byte discards the partial
        frame_start();
        for (int i = 0; i < 4; i++) send_bit(1'b1, m);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        half_period();
        send_byte(8'h81, echo);
        frame_end();
        check_eq("rst_mid_byte", {24'd0, spi_byte}, 32'h0000_0081);
        check_eq("rst_mid_ferr", ferr_cnt, 1);

        // Echo link check: second frame's MISO carries the first frame's byte
        frame_start();
        send_byte(8'h5A, echo);
        frame_end();
        frame_start();
        send_byte(8'h00, echo);
        frame_end();
`ifdef QOA_SPI_ECHO_EN
        check_eq("echo_miso", {24'd0, echo}, 32'h0000_005A);
`else
        check_eq("echo_miso", {24'd0, echo}, 32'h0000_0000);
`endif

        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 50) begin
            @(negedge sys_clk);
            wait_cycles++;
        end
        check_eq("queue_empty", exp_q.size(), 0);
        check_eq("total_rdy", rdy_cnt, 9);
        check_eq("total_ferr", ferr_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
